axis_tx_arbiter: RTL and testbench
==================================

AXIS_TX_ARBITER -- requirements
Module: axis_tx_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 128, meaning AXI-Stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning number of requester streams (2..16).
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of each per-requester packet counter.
REQ-004 Port tx_clk  in  1  single clock; all logic is on its rising edge.
REQ-005 Port rst  in  1  reset, synchronous and active-high.
REQ-006 Port link_up  in  1  when high, new packet grants are permitted.
REQ-007 Port s_axis_tdata  in  NUM_REQ*DWIDTH  requester data, requester k in slice k.
REQ-008 Port s_axis_tkeep  in  NUM_REQ*DWIDTH/8  requester byte enables.
REQ-009 Port s_axis_tlast, s_axis_tvalid  in  NUM_REQ each  per-requester last and valid.
REQ-010 Port s_axis_tready  out  NUM_REQ  per-requester ready.
REQ-011 Port m_axis_tdata/tkeep/tlast/tvalid  out  DWIDTH/DWIDTH/8/1/1  merged stream to the link.
REQ-012 Port m_axis_tready  in  1  link ready.
REQ-013 Port grant_id  out  $clog2(NUM_REQ)  index of the currently granted requester.
REQ-014 Port busy  out  1  high while in state BUSY.

Function
REQ-015 SHALL arbitrate whole packets: once granted, requester keeps the output until its tlast beat handshakes.
REQ-016 SHALL implement states IDLE and BUSY.
REQ-017 In IDLE with link_up=1 and any s_axis_tvalid high: register grant, go to BUSY next cycle.
REQ-018 In IDLE with link_up=0: no grant; stay in IDLE.
REQ-019 Grant SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, then ascending with wrap; first valid wins.
REQ-020 In BUSY, m_axis_* SHALL equal the granted requester's signals combinationally, and s_axis_tready[grant] = m_axis_tready.
REQ-021 In BUSY, all non-granted s_axis_tready SHALL be 0.
REQ-022 In IDLE, m_axis_tvalid and all s_axis_tready SHALL be 0; m_axis_tdata/tkeep/tlast SHALL be 0.
REQ-023 Handshake of tlast=1 beat in BUSY: return to IDLE; last_grant <= grant.
REQ-024 One idle bubble cycle between packets; first-beat latency is 1 cycle after tvalid is sampled in IDLE.
REQ-025 link_up falling during BUSY SHALL NOT abort the packet; it only blocks the next grant.
REQ-026 A granted requester that drops tvalid mid-packet SHALL keep the grant (no timeout).
REQ-027 Single-beat packet (tvalid and tlast together): IDLE -> BUSY -> IDLE in 2 cycles when m_axis_tready=1.

Reset
REQ-028 On rst=1: state IDLE, grant_id 0, last_grant NUM_REQ-1 (so requester 0 has first priority), busy 0, counters 0.
REQ-029 rst asserted mid-packet SHALL abandon the packet immediately; there is no beat replay.

Configuration
REQ-030 Macro AXIS_ARB_STATS_EN SHALL control per-requester statistics.
REQ-031 With AXIS_ARB_STATS_EN: output pkt_cnt (NUM_REQ*CNT_W) SHALL increment slice k on each tlast handshake of requester k, wrapping at 2^CNT_W.
REQ-032 Without AXIS_ARB_STATS_EN: port pkt_cnt and counters SHALL be absent.

Structure
REQ-033 Package axis_arb_pkg SHALL hold the state enum (IDLE, BUSY) and default parameter constants.
REQ-034 Sub-module rr_priority_picker SHALL perform the combinational rotate-and-priority-encode (inputs: req vector, last_grant; outputs: grant index, any).

Verification
REQ-035 Reqs 0 and 2 each send a 3-beat packet simultaneously after reset -> req 0 forwarded first, 1 bubble, then req 2; 7 cycles total with tready=1.
REQ-036 All 4 requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0,...; with stats, each pkt_cnt is 25 after 100 packets.
REQ-037 m_axis_tready toggled 1010... during a 4-beat packet of req 1 -> 4 beats out in order, data stable while stalled, s_axis_tready[1] tracks m_axis_tready.
REQ-038 link_up=0 with req 3 valid -> no m_axis_tvalid for 20 cycles; link_up=1 -> req 3 first beat 1 cycle later.
REQ-039 link_up dropped on beat 2 of a 5-beat packet -> all 5 beats delivered, then IDLE until link_up returns.
REQ-040 rst pulsed on beat 2 of a 4-beat packet -> next cycle m_axis_tvalid=0, busy=0, grant_id=0, and the next grant goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
//   Shared definitions for the AXI-Stream transmit arbiter:
//     - arb_state_t : arbiter FSM state (IDLE, BUSY)
//     - *_DEF       : default parameter values used by axis_tx_arbiter
//     - rr_index()  : round-robin candidate index helper
// ---------------------------------------------------------------------------
package axis_arb_pkg;

   localparam int DWIDTH_DEF  = 128;  // AXI-Stream data width in bits
   localparam int NUM_REQ_DEF = 4;    // number of requester streams
   localparam int CNT_W_DEF   = 32;   // per-requester packet counter width

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Candidate index 'offset' positions after 'last', wrapping at 'num'.
   function automatic int rr_index(input int last, input int offset, input int num);
      return (last + offset) % num;
   endfunction

endpackage

// File: rtl/axis_tx_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
//   Combinational rotate-and-priority-encode. The search starts at the
//   requester after last_grant and walks upward with wrap-around; the first
//   requester with its req bit set wins.
//
// Ports
//   req        in  NUM_REQ          request vector (one bit per requester)
//   last_grant in  $clog2(NUM_REQ)  most recently served requester
//   grant      out $clog2(NUM_REQ)  winning requester (0 when none)
//   any        out 1                at least one requester is asking
// ---------------------------------------------------------------------------
module rr_priority_picker
   import axis_arb_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   localparam int GW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GW-1:0]      last_grant,
   output logic [GW-1:0]      grant,
   output logic               any
);

   int idx;

   // Offsets run 1..NUM_REQ so that last_grant itself is the lowest priority
   // candidate and is still picked when it is the only one asking.
   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = rr_index(int'(last_grant), i, NUM_REQ);
         if (!any && req[idx]) begin
            grant = GW'(idx);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_tx_arbiter.sv
// ---------------------------------------------------------------------------
// axis_tx_arbiter
//   Packet-level round-robin arbiter merging NUM_REQ AXI-Stream requesters
//   onto one transmit link. A granted requester owns the output until its
//   tlast beat is accepted; one idle cycle separates consecutive packets.
//
// Optional feature
//   AXIS_ARB_STATS_EN : when defined, adds the pkt_cnt output carrying one
//                       CNT_W-bit wrapping packet counter per requester.
//
// Ports
//   tx_clk         in   1                  clock, rising edge
//   rst            in   1                  synchronous active-high reset
//   link_up        in   1                  new packet grants permitted
//   s_axis_tdata   in   NUM_REQ*DWIDTH     requester data, slice k = req k
//   s_axis_tkeep   in   NUM_REQ*DWIDTH/8   requester byte enables
//   s_axis_tlast   in   NUM_REQ            requester last-beat flags
//   s_axis_tvalid  in   NUM_REQ            requester valids
//   s_axis_tready  out  NUM_REQ            requester readies
//   m_axis_tdata   out  DWIDTH             merged stream data
//   m_axis_tkeep   out  DWIDTH/8           merged stream byte enables
//   m_axis_tlast   out  1                  merged stream last
//   m_axis_tvalid  out  1                  merged stream valid
//   m_axis_tready  in   1                  link ready
//   grant_id       out  $clog2(NUM_REQ)    currently granted requester
//   busy           out  1                  FSM is in BUSY
//   dbg_state      out  arb_state_t        raw FSM state
//   pkt_cnt        out  NUM_REQ*CNT_W      packet counters (stats build only)
// ---------------------------------------------------------------------------
module axis_tx_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int DWIDTH  = DWIDTH_DEF,
   parameter  int NUM_REQ = NUM_REQ_DEF,
   parameter  int CNT_W   = CNT_W_DEF,
   localparam int KW      = DWIDTH / 8,
   localparam int GW      = $clog2(NUM_REQ)
) (
   input  logic                      tx_clk,
   input  logic                      rst,
   input  logic                      link_up,
   input  logic [NUM_REQ*DWIDTH-1:0] s_axis_tdata,
   input  logic [NUM_REQ*KW-1:0]     s_axis_tkeep,
   input  logic [NUM_REQ-1:0]        s_axis_tlast,
   input  logic [NUM_REQ-1:0]        s_axis_tvalid,
   output logic [NUM_REQ-1:0]        s_axis_tready,
   output logic [DWIDTH-1:0]         m_axis_tdata,
   output logic [KW-1:0]             m_axis_tkeep,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [GW-1:0]             grant_id,
   output logic                      busy,
   output arb_state_t                dbg_state
`ifdef AXIS_ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0]  pkt_cnt
`endif
);

   // Handshake rule for every stream here: a beat transfers on a rising
   // tx_clk edge where tvalid and tready are both high. tvalid never waits
   // on tready; data/keep/last are held by the source while tvalid is high
   // and tready is low. The arbiter only forwards, so m_axis_tvalid is the
   // granted source's tvalid and that source's tready is the link's tready.

   arb_state_t        state;
   logic [GW-1:0]     last_grant;
   logic [GW-1:0]     pick_id;
   logic              pick_any;
   logic              pkt_done;

   logic [DWIDTH-1:0] req_data [NUM_REQ];
   logic [KW-1:0]     req_keep [NUM_REQ];

   // Unpack the flat requester buses so the output mux is a plain index.
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign req_data[k] = s_axis_tdata[k*DWIDTH +: DWIDTH];
      assign req_keep[k] = s_axis_tkeep[k*KW +: KW];
   end

   rr_priority_picker #(
      .NUM_REQ    (NUM_REQ)
   ) u_picker (
      .req        (s_axis_tvalid),
      .last_grant (last_grant),
      .grant      (pick_id),
      .any        (pick_any)
   );

   // Output mux: transparent to the granted requester while BUSY, all-zero
   // while IDLE so the link never sees stale data between packets.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      if (state == BUSY) begin
         m_axis_tdata            = req_data[grant_id];
         m_axis_tkeep            = req_keep[grant_id];
         m_axis_tlast            = s_axis_tlast[grant_id];
         m_axis_tvalid           = s_axis_tvalid[grant_id];
         s_axis_tready[grant_id] = m_axis_tready;
      end
   end

   assign pkt_done  = (state == BUSY) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
   assign dbg_state = state;

   // Arbitration FSM. link_up is only consulted in IDLE, so a link drop
   // lets the packet in flight finish and merely blocks the next grant.
   // A granted requester keeps ownership through any tvalid gap.
   always_ff @(posedge tx_clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (link_up && pick_any) begin
                  grant_id <= pick_id;
                  state    <= BUSY;
                  busy     <= 1'b1;
               end
            end
            BUSY: begin
               if (pkt_done) begin
                  last_grant <= grant_id;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef AXIS_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_q [NUM_REQ];

   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge tx_clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cnt_q[k] <= '0;
         end
      end else if (pkt_done) begin
         cnt_q[grant_id] <= cnt_q[grant_id] + 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt_pack
      assign pkt_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
   end
`endif

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_tx_arbiter
//   Self-checking bench for axis_tx_arbiter (DWIDTH=32, NUM_REQ=4, CNT_W=16).
//   Each requester is modelled by a queue of beats; every beat a scenario
//   expects on the link is pushed to exp_q in the order arbitration must
//   produce it, and popped when the link handshakes.
//   Build with AXIS_ARB_STATS_EN defined to also check pkt_cnt.
// ---------------------------------------------------------------------------
module tb_axis_tx_arbiter;
  import axis_arb_pkg::*;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int CW = 16;
  localparam int KW = DW / 8;
  localparam int GW = 2;
  localparam int BW = DW + KW + 1;   // {data, keep, last}
  localparam int EW = GW + BW;       // {source id, beat}

  // ---------------- clock / reset ----------------
  logic tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  logic              rst = 1'b1;
  logic              link_up = 1'b0;
  logic [NR*DW-1:0]  s_axis_tdata = '0;
  logic [NR*KW-1:0]  s_axis_tkeep = '0;
  logic [NR-1:0]     s_axis_tlast = '0;
  logic [NR-1:0]     s_axis_tvalid = '0;
  logic [NR-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [GW-1:0]     grant_id;
  logic              busy;
  arb_state_t        dbg_state;
`ifdef AXIS_ARB_STATS_EN
  logic [NR*CW-1:0]  pkt_cnt;
`endif

  axis_tx_arbiter #(
    .DWIDTH (DW),
    .NUM_REQ(NR),
    .CNT_W  (CW)
  ) dut (
    .tx_clk       (tx_clk),
    .rst          (rst),
    .link_up      (link_up),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .grant_id     (grant_id),
    .busy         (busy),
    .dbg_state    (dbg_state)
`ifdef AXIS_ARB_STATS_EN
    ,
    .pkt_cnt      (pkt_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] src_q [NR][$];
  logic [EW-1:0] exp_q [$];
  logic [NR-1:0] hold = '0;
  logic [NR-1:0] hs;
  int tests_run = 0;
  int tests_failed = 0;
  int hs_total = 0;
  int pkt_seq = 0;

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input int k, input int n, input bit add_exp);
    logic [BW-1:0] w;
    for (int b = 0; b < n; b++) begin
      w = {8'(k), 8'(pkt_seq), 8'(b), 8'($urandom), 4'($urandom_range(1, 15)), (b == n - 1)};
      src_q[k].push_back(w);
      if (add_exp) exp_q.push_back({GW'(k), w});
    end
    pkt_seq++;
  endtask

  // Drive sources, move to the negedge and score any link handshake.
  task automatic cycle_begin();
    logic [BW-1:0] w;
    logic [EW-1:0] e;
    for (int k = 0; k < NR; k++) begin
      if (src_q[k].size() > 0 && !hold[k]) begin
        w = src_q[k][0];
        s_axis_tdata[k*DW +: DW] = w[BW-1 -: DW];
        s_axis_tkeep[k*KW +: KW] = w[KW:1];
        s_axis_tlast[k]          = w[0];
        s_axis_tvalid[k]         = 1'b1;
      end else begin
        s_axis_tdata[k*DW +: DW] = '0;
        s_axis_tkeep[k*KW +: KW] = '0;
        s_axis_tlast[k]          = 1'b0;
        s_axis_tvalid[k]         = 1'b0;
      end
    end
    @(negedge tx_clk);
    hs = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      hs_total++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_extra_beat: got grant=%0d data=%h, required no beat", grant_id, m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== e) begin
          tests_failed++;
          $display("FAIL sb_beat: got {id,data,keep,last}=%h, required %h",
                   {grant_id, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, e);
        end
      end
    end
  endtask

  // Cross the active edge and retire beats the sources saw accepted.
  task automatic cycle_end();
    @(posedge tx_clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    end
  endtask

  task automatic drain(input int budget, input string name);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      cycle_begin();
      cycle_end();
      i++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_timeout: got %0d beats outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
      for (int k = 0; k < NR; k++) src_q[k].delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    link_up = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) begin
      cycle_begin();
      cycle_end();
    end
    cycle_begin();
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got tvalid=%b busy=%b grant=%0d state=%0d, required 0 0 0 0",
               m_axis_tvalid, busy, grant_id, dbg_state);
    end
    tests_run++;
    if (s_axis_tready !== 4'b0000 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got tready=%b data=%h keep=%h last=%b, required all 0",
               s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
`ifdef AXIS_ARB_STATS_EN
    tests_run++;
    if (pkt_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_pkt_cnt: got %h, required 0", pkt_cnt);
    end
`endif
    cycle_end();
    rst = 1'b0;
  endtask

  task automatic test_two_packets();
    int log_c[$];
    int exp_c[6];
    int i;
    exp_c = '{1, 2, 3, 5, 6, 7};
    link_up = 1'b1;
    m_axis_tready = 1'b1;
    push_pkt(0, 3, 1);
    push_pkt(2, 3, 1);
    i = 0;
    while (exp_q.size() > 0 && i < 40) begin
      cycle_begin();
      if (m_axis_tvalid && m_axis_tready) log_c.push_back(i);
      cycle_end();
      i++;
    end
    drain(1, "two_pkt");
    for (int j = 0; j < 6; j++) begin
      tests_run++;
      if (j >= log_c.size() || log_c[j] != exp_c[j]) begin
        tests_failed++;
        $display("FAIL two_pkt_timing: beat %0d got cycle %0d, required %0d",
                 j, (j < log_c.size()) ? log_c[j] : -1, exp_c[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    cycle_begin();
    cycle_end();
    rst = 1'b0;
    m_axis_tready = 1'b1;
    link_up = 1'b1;
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < NR; k++) push_pkt(k, 1, 1);
    end
    drain(400, "round_robin");
`ifdef AXIS_ARB_STATS_EN
    for (int k = 0; k < NR; k++) begin
      tests_run++;
      if (pkt_cnt[k*CW +: CW] !== 16'd25) begin
        tests_failed++;
        $display("FAIL rr_pkt_cnt%0d: got %0d, required 25", k, pkt_cnt[k*CW +: CW]);
      end
    end
`endif
  endtask

  task automatic test_backpressure();
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    int i;
    prev_stall = 1'b0;
    prev_data  = '0;
    push_pkt(1, 4, 1);
    i = 0;
    while (exp_q.size() > 0 && i < 40) begin
      m_axis_tready = (i % 2 == 0);
      cycle_begin();
      if (busy) begin
        tests_run++;
        if (s_axis_tready[1] !== m_axis_tready || (s_axis_tready & 4'b1101) !== 4'b0000) begin
          tests_failed++;
          $display("FAIL bp_tready: got s_tready=%b with m_tready=%b, required bit1 only tracking",
                   s_axis_tready, m_axis_tready);
        end
      end
      if (prev_stall) begin
        tests_run++;
        if (m_axis_tdata !== prev_data || m_axis_tvalid !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_stable: got data=%h valid=%b, required %h 1", m_axis_tdata, m_axis_tvalid, prev_data);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      cycle_end();
      i++;
    end
    drain(1, "backpressure");
    m_axis_tready = 1'b1;
  endtask

  task automatic test_link_down();
    link_up = 1'b0;
    m_axis_tready = 1'b1;
    push_pkt(3, 1, 1);
    for (int i = 0; i < 20; i++) begin
      cycle_begin();
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL link_down_hold: cycle %0d got tvalid=%b busy=%b, required 0 0", i, m_axis_tvalid, busy);
      end
      cycle_end();
    end
    link_up = 1'b1;
    cycle_begin();
    tests_run++;
    if (m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL link_up_edge: got tvalid=%b, required 0", m_axis_tvalid);
    end
    cycle_end();
    cycle_begin();
    tests_run++;
    if (m_axis_tvalid !== 1'b1 || grant_id !== 2'd3) begin
      tests_failed++;
      $display("FAIL link_up_first_beat: got tvalid=%b grant=%0d, required 1 3", m_axis_tvalid, grant_id);
    end
    cycle_end();
    drain(5, "link_down");
  endtask

  task automatic test_valid_gap();
    int start;
    int i;
    push_pkt(0, 3, 1);
    push_pkt(1, 1, 1);
    start = hs_total;
    i = 0;
    while (hs_total < start + 1 && i < 10) begin
      cycle_begin();
      cycle_end();
      i++;
    end
    hold[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle_begin();
      tests_run++;
      if (busy !== 1'b1 || grant_id !== 2'd0 || m_axis_tvalid !== 1'b0 || s_axis_tready[1] !== 1'b0) begin
        tests_failed++;
        $display("FAIL gap_keep_grant: got busy=%b grant=%0d tvalid=%b s_tready1=%b, required 1 0 0 0",
                 busy, grant_id, m_axis_tvalid, s_axis_tready[1]);
      end
      cycle_end();
    end
    hold[0] = 1'b0;
    drain(20, "valid_gap");
  endtask

  task automatic test_link_drop();
    int start;
    int i;
    link_up = 1'b1;
    m_axis_tready = 1'b1;
    push_pkt(0, 5, 1);
    push_pkt(1, 1, 1);
    start = hs_total;
    i = 0;
    while (hs_total < start + 5 && i < 30) begin
      cycle_begin();
      cycle_end();
      if (hs_total == start + 1) link_up = 1'b0;
      i++;
    end
    tests_run++;
    if (hs_total != start + 5) begin
      tests_failed++;
      $display("FAIL link_drop_beats: got %0d beats, required 5", hs_total - start);
    end
    for (int j = 0; j < 10; j++) begin
      cycle_begin();
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL link_drop_idle: cycle %0d got tvalid=%b busy=%b, required 0 0", j, m_axis_tvalid, busy);
      end
      cycle_end();
    end
    link_up = 1'b1;
    drain(10, "link_drop");
  endtask

  task automatic test_reset_mid();
    int start;
    int i;
    logic [BW-1:0] w;
    link_up = 1'b1;
    m_axis_tready = 1'b1;
    push_pkt(2, 4, 0);
    for (int b = 0; b < 2; b++) begin
      w = src_q[2][b];
      exp_q.push_back({2'd2, w});
    end
    push_pkt(0, 2, 1);
    push_pkt(1, 2, 1);
    push_pkt(3, 2, 1);
    start = hs_total;
    i = 0;
    while (hs_total < start + 1 && i < 10) begin
      cycle_begin();
      cycle_end();
      i++;
    end
    rst = 1'b1;
    cycle_begin();
    cycle_end();
    rst = 1'b0;
    src_q[2].delete();
    cycle_begin();
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_state: got tvalid=%b busy=%b grant=%0d, required 0 0 0", m_axis_tvalid, busy, grant_id);
    end
`ifdef AXIS_ARB_STATS_EN
    tests_run++;
    if (pkt_cnt !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_pkt_cnt: got %h, required 0", pkt_cnt);
    end
`endif
    cycle_end();
    drain(40, "reset_mid");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(posedge tx_clk);
    #1;
    test_reset();
    test_two_packets();
    test_round_robin();
    test_backpressure();
    test_link_down();
    test_valid_gap();
    test_link_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1000000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
